// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared types and constants for the PPI bus interface
package ppi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_ACT = 2'd1,
        RD_ACT = 2'd2
    } ppi_state_e;

    localparam logic [1:0] ADDR_A    = 2'b00;
    localparam logic [1:0] ADDR_B    = 2'b01;
    localparam logic [1:0] ADDR_C    = 2'b10;
    localparam logic [1:0] ADDR_CTRL = 2'b11;

    localparam logic [7:0] CTRL_RESET = 8'h9B;

    // A control byte with D7 set is a mode word; D7 clear is a bit set/reset command.
    function automatic logic is_mode_word(input logic [7:0] b);
        return b[7];
    endfunction

endpackage

// File: rtl/ppi_sync2.sv
// rtl/ppi_sync2.sv - two-flop synchronizer for active-low CPU strobes
module ppi_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Reset to 1 so that strobes read as inactive while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ppi_bus_interface.sv
// rtl/ppi_bus_interface.sv - CPU-side bus interface of an 8255-style PPI
module ppi_bus_interface
    import ppi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    input  logic [7:0] port_a_in,
    input  logic [7:0] port_b_in,
    input  logic [7:0] port_c_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       control_logic,
    output logic [7:0] bus_cpu,
    output logic [7:0] ctrl_word,
    output logic       wr_a,
    output logic       wr_b,
    output logic       wr_c,
    output logic [7:0] wr_data
);

    logic cs_s;
    logic rd_s;
    logic wr_s;

    ppi_state_e state_q;
    ppi_state_e state_d;

    logic cap_en;
    logic commit;
    logic rd_en;

    logic [1:0] addr_cap_q;
    logic [7:0] data_cap_q;
    logic [7:0] data_out_q;
    logic [7:0] ctrl_word_q;
    logic [7:0] bus_cpu_q;
    logic [7:0] wr_data_q;
    logic       wr_a_q;
    logic       wr_b_q;
    logic       wr_c_q;
    logic       control_logic_q;

    ppi_sync2 u_sync_cs (.clk(clk), .rst_n(rst_n), .d_i(cs_n), .q_o(cs_s));
    ppi_sync2 u_sync_rd (.clk(clk), .rst_n(rst_n), .d_i(rd_n), .q_o(rd_s));
    ppi_sync2 u_sync_wr (.clk(clk), .rst_n(rst_n), .d_i(wr_n), .q_o(wr_s));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: write beats read when both strobes are low; busy states ignore the other strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!cs_s && !wr_s) begin
                    state_d = WR_ACT;
                end else if (!cs_s && !rd_s) begin
                    state_d = RD_ACT;
                end
            end
            WR_ACT: begin
                if (wr_s || cs_s) begin
                    state_d = IDLE;
                end
            end
            RD_ACT: begin
                if (rd_s || cs_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: capture while a write is held, commit on write exit, read mux while reading.
    always_comb begin
        cap_en  = 1'b0;
        commit  = 1'b0;
        rd_en   = 1'b0;
        data_oe = 1'b0;
        case (state_q)
            IDLE: begin
                cap_en = (state_d == WR_ACT);
                rd_en  = (state_d == RD_ACT);
            end
            WR_ACT: begin
                cap_en = (state_d == WR_ACT);
                commit = (state_d == IDLE);
            end
            RD_ACT: begin
                data_oe = 1'b1;
                rd_en   = (state_d == RD_ACT);
            end
            default: begin
                cap_en = 1'b0;
            end
        endcase
    end

    // Latch the most recent address/data seen while the write strobe is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cap_q <= 2'b00;
            data_cap_q <= 8'h00;
        end else if (cap_en) begin
            addr_cap_q <= addr;
            data_cap_q <= data_in;
        end
    end

    // Commit the captured write as a single-cycle strobe and update control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_a_q          <= 1'b0;
            wr_b_q          <= 1'b0;
            wr_c_q          <= 1'b0;
            control_logic_q <= 1'b0;
            wr_data_q       <= 8'h00;
            bus_cpu_q       <= CTRL_RESET;
            ctrl_word_q     <= CTRL_RESET;
        end else begin
            wr_a_q          <= 1'b0;
            wr_b_q          <= 1'b0;
            wr_c_q          <= 1'b0;
            control_logic_q <= 1'b0;
            if (commit) begin
                case (addr_cap_q)
                    ADDR_A: begin
                        wr_a_q    <= 1'b1;
                        wr_data_q <= data_cap_q;
                    end
                    ADDR_B: begin
                        wr_b_q    <= 1'b1;
                        wr_data_q <= data_cap_q;
                    end
                    ADDR_C: begin
                        wr_c_q    <= 1'b1;
                        wr_data_q <= data_cap_q;
                    end
                    ADDR_CTRL: begin
                        control_logic_q <= 1'b1;
                        bus_cpu_q       <= data_cap_q;
                        if (is_mode_word(data_cap_q)) begin
                            ctrl_word_q <= data_cap_q;
                        end
                    end
                    default: begin
                        wr_data_q <= wr_data_q;
                    end
                endcase
            end
        end
    end

    // Read data follows addr while the read stays active and holds once it ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= 8'h00;
        end else if (rd_en) begin
            case (addr)
                ADDR_A:  data_out_q <= port_a_in;
                ADDR_B:  data_out_q <= port_b_in;
                ADDR_C:  data_out_q <= port_c_in;
                default: data_out_q <= ctrl_word_q;
            endcase
        end
    end

    assign data_out      = data_out_q;
    assign control_logic = control_logic_q;
    assign bus_cpu       = bus_cpu_q;
    assign ctrl_word     = ctrl_word_q;
    assign wr_a          = wr_a_q;
    assign wr_b          = wr_b_q;
    assign wr_c          = wr_c_q;
    assign wr_data       = wr_data_q;

endmodule

// File: doc/ppi_bus_interface.md
PPI_BUS_INTERFACE -- requirements
Module: ppi_bus_interface

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cs_n  in  1  CPU chip select, active low, asynchronous to clk.
REQ-005 rd_n  in  1  CPU read strobe, active low, asynchronous to clk.
REQ-006 wr_n  in  1  CPU write strobe, active low, asynchronous to clk.
REQ-007 addr  in  2  A1:A0; 00 port A, 01 port B, 10 port C, 11 control.
REQ-008 data_in  in  8  CPU write data.
REQ-009 port_a_in, port_b_in, port_c_in  in  8 each  port read-back values.
REQ-010 data_out  out  8  registered CPU read data.
REQ-011 data_oe  out  1  high while CPU read is active; drives the external tri-state.
REQ-012 control_logic  out  1  one-cycle strobe: control-register write committed.
REQ-013 bus_cpu  out  8  last committed control-register byte; held until next control write.
REQ-014 ctrl_word  out  8  current mode word; updated only by writes with D7=1.
REQ-015 wr_a, wr_b, wr_c  out  1 each  one-cycle port write strobes.
REQ-016 wr_data  out  8  data for the port write strobes; valid while a strobe is high.

Function
REQ-017 cs_n, rd_n, wr_n SHALL each pass through a 2-flop synchronizer (cs_s, rd_s, wr_s); addr and data_in are sampled unsynchronized.
REQ-018 FSM states: IDLE, WR_ACT, RD_ACT.
REQ-019 IDLE -> WR_ACT when cs_s=0 and wr_s=0; IDLE -> RD_ACT when cs_s=0, rd_s=0, wr_s=1 (write wins when both are low).
REQ-020 In WR_ACT, addr and data_in SHALL be captured every cycle while cs_s=0 and wr_s=0; the last captured value is committed.
REQ-021 WR_ACT -> IDLE when wr_s=1 or cs_s=1; in the cycle after that transition exactly one strobe SHALL pulse high for one clk.
REQ-022 Commit addr 00/01/10 -> wr_a/wr_b/wr_c with wr_data = captured byte.
REQ-023 Commit addr 11 -> control_logic pulse, bus_cpu = captured byte; ctrl_word = captured byte only if D7=1 (a BSR write leaves ctrl_word unchanged).
REQ-024 In RD_ACT, data_oe=1 and data_out updates every cycle from addr: port_a_in, port_b_in, port_c_in, or ctrl_word for 11.
REQ-025 RD_ACT -> IDLE when rd_s=1 or cs_s=1; data_oe SHALL drop in that same transition cycle, and data_out holds its last value.
REQ-026 wr_s going low during RD_ACT SHALL be ignored until the FSM returns to IDLE.
REQ-027 Total write latency: 3 clk from wr_n rising to strobe (2 sync + 1 registered strobe).
REQ-028 A new access needs cs_s, wr_s and rd_s to pass through IDLE; there is no back-to-back commit without an IDLE cycle.

Reset
REQ-029 On rst_n=0, immediately: state=IDLE, synchronizer flops=1, ctrl_word=8'h9B, bus_cpu=8'h9B, data_out=0, data_oe=0, all strobes=0, wr_data=0.
REQ-030 Reset during WR_ACT SHALL abort the write; no strobe issues after reset release.

Structure
REQ-031 Package ppi_pkg SHALL hold the state enum, address constants (ADDR_A/B/C/CTRL), and CTRL_RESET=8'h9B.
REQ-032 Sub-module ppi_sync2 (2-flop synchronizer, async reset to 1) SHALL be instantiated three times.

Verification
REQ-033 Reset release -> ctrl_word=8'h9B, bus_cpu=8'h9B, data_oe=0, no strobes.
REQ-034 Write addr=11, data=8'h80 -> single control_logic pulse 3 clk after wr_n rises; bus_cpu=ctrl_word=8'h80.
REQ-035 Then write addr=11, data=8'h0F (BSR) -> control_logic pulse, bus_cpu=8'h0F, ctrl_word stays 8'h80.
REQ-036 Write addr=01, data=8'h5A -> wr_b high for exactly 1 clk with wr_data=8'h5A; wr_a, wr_c and control_logic stay 0.
REQ-037 Read addr=10 with port_c_in=8'hC3 -> data_oe=1 after 2-3 clk, data_out=8'hC3; data_oe=0 after rd_n rises; wr_n pulsed mid-read produces no strobe.
REQ-038 Assert rst_n=0 while wr_n is low, release after wr_n rises -> no strobe, ctrl_word=8'h9B.
